ex_stage: RTL and testbench

Execute stage of the pipelined MIPS, directly downstream of the ID/EX pipeline register. It performs operand forwarding, ALU operations, branch-target and zero-flag generation, and a 32-cycle iterative multiply that stalls the front end. It also owns the EX/MEM pipeline register, so all results leave the block registered.

---
 rtl/ex_stage.sv | 127 ++++++++++++
 tb/tb_ex_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with forwarding, ALU, branch target, iterative multiply and EX/MEM register
module ex_stage #(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  input  logic             branch_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             reg_dst_in,
  input  logic             alu_src_in,
  input  logic [2:0]       alu_op_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] read_data1_in,
  input  logic [WIDTH-1:0] read_data2_in,
  input  logic [WIDTH-1:0] sign_ext_in,
  input  logic [4:0]       rs_in,
  input  logic [4:0]       rt_in,
  input  logic [4:0]       rd_in,
  input  logic             memwb_reg_write,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             stall,
  output logic             reg_write_out,
  output logic             mem_to_reg_out,
  output logic             branch_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] write_data_out,
  output logic [WIDTH-1:0] branch_target_out,
  output logic             zero_out,
  output logic [4:0]       write_reg_out
);
  localparam int CW = $clog2(MUL_ITER);
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_sum;
  logic [4:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d, write_data_q, write_data_d;
  logic [WIDTH-1:0] branch_target_q, branch_target_d;
  logic             zero_q, zero_d;
  logic [4:0]       write_reg_q, write_reg_d;
  logic [WIDTH-1:0] fwd_a, fwd_b, alu_b, alu_res;
  logic             is_mul, last, load;
  assign is_mul  = alu_op_in == 3'b011;
  assign last    = state_q == BUSY && cnt_q == CW'(MUL_ITER - 1);
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = flush ? IDLE : state_q == IDLE ? (is_mul ? BUSY : IDLE) : (last ? IDLE : BUSY);
  always_comb begin
    stall = reset && !flush && (state_q == IDLE ? is_mul : !last);
    load  = !flush && (state_q == IDLE ? !is_mul : last);
  end
  // EX/MEM is the youngest producer, so it takes priority over MEM/WB
  always_comb begin
    fwd_a = (ctl_q[4] && |write_reg_q && write_reg_q == rs_in) ? alu_result_q :
            (memwb_reg_write && |memwb_rd && memwb_rd == rs_in) ? memwb_data : read_data1_in;
    fwd_b = (ctl_q[4] && |write_reg_q && write_reg_q == rt_in) ? alu_result_q :
            (memwb_reg_write && |memwb_rd && memwb_rd == rt_in) ? memwb_data : read_data2_in;
    alu_b = alu_src_in ? sign_ext_in : fwd_b;
  end
  always_comb begin
    case (alu_op_in)
      3'b000:  alu_res = fwd_a & alu_b;
      3'b001:  alu_res = fwd_a | alu_b;
      3'b010:  alu_res = fwd_a + alu_b;
      3'b100:  alu_res = ~(fwd_a | alu_b);
      3'b101:  alu_res = fwd_a ^ alu_b;
      3'b110:  alu_res = fwd_a - alu_b;
      3'b111:  alu_res = {{(WIDTH-1){1'b0}}, $signed(fwd_a) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end
  // operands are re-latched every idle cycle so the acceptance cycle captures them
  always_comb begin
    cnt_d           = state_q == IDLE ? '0 : cnt_q + 1'b1;
    mcand_d         = state_q == IDLE ? fwd_a : mcand_q << 1;
    mplier_d        = state_q == IDLE ? alu_b : mplier_q >> 1;
    acc_d           = state_q == IDLE ? '0 : acc_sum;
    ctl_d           = load ? {reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in} : '0;
    alu_result_d    = state_q == BUSY ? acc_sum : alu_res;
    zero_d          = alu_result_d == '0;
    write_data_d    = fwd_b;
    branch_target_d = pc_in + (sign_ext_in << 2);
    write_reg_d     = reg_dst_in ? rd_in : rt_in;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q           <= '0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      acc_q           <= '0;
      ctl_q           <= '0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      write_data_q    <= '0;
      branch_target_q <= '0;
      write_reg_q     <= '0;
    end else begin
      cnt_q           <= cnt_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      acc_q           <= acc_d;
      ctl_q           <= ctl_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      write_data_q    <= write_data_d;
      branch_target_q <= branch_target_d;
      write_reg_q     <= write_reg_d;
    end
  assign {reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out} = ctl_q;
  assign alu_result_out    = alu_result_q;
  assign zero_out          = zero_q;
  assign write_data_out    = write_data_q;
  assign branch_target_out = branch_target_q;
  assign write_reg_out     = write_reg_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed bench for ex_stage against a cycle-level reference model
module tb_ex_stage;
  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_MUL = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4, OP_XOR = 3'd5, OP_SUB = 3'd6, OP_SLT = 3'd7;
  logic clk = 1'b0, reset, flush;
  logic reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in, reg_dst_in, alu_src_in;
  logic [2:0] alu_op_in;
  logic [31:0] pc_in, read_data1_in, read_data2_in, sign_ext_in, memwb_data;
  logic [4:0] rs_in, rt_in, rd_in, memwb_rd;
  logic memwb_reg_write;
  logic stall, reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out, zero_out;
  logic [31:0] alu_result_out, write_data_out, branch_target_out;
  logic [4:0] write_reg_out;
  int checks = 0, failures = 0;
  logic m_rw, m_mtr, m_br, m_mr, m_mw, m_zero, m_bub, m_busy;
  logic [31:0] m_res, m_wd, m_bt, m_prod;
  logic [4:0] m_wr;
  int m_left;

  ex_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_dst_in(reg_dst_in),
    .alu_src_in(alu_src_in), .alu_op_in(alu_op_in), .pc_in(pc_in),
    .read_data1_in(read_data1_in), .read_data2_in(read_data2_in), .sign_ext_in(sign_ext_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall(stall), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .branch_out(branch_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out),
    .branch_target_out(branch_target_out), .zero_out(zero_out), .write_reg_out(write_reg_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return rf;
    if (m_rw && m_wr == r) return m_res;
    if (memwb_reg_write && memwb_rd == r) return memwb_data;
    return rf;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_NOR:  return ~(a | b);
      OP_XOR:  return a ^ b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    {m_rw, m_mtr, m_br, m_mr, m_mw, m_zero, m_bub, m_busy} = '0;
    {m_res, m_wd, m_bt, m_prod} = '0;
    m_wr = '0;
    m_left = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out}), 32'd0);
    check({tag, "_res"}, alu_result_out, 32'd0);
    check({tag, "_wd"}, write_data_out, 32'd0);
    check({tag, "_bt"}, branch_target_out, 32'd0);
    check({tag, "_zero_wr"}, 32'({zero_out, write_reg_out}), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // one clock of the pipeline: check stall, predict the EX/MEM load, compare after the edge
  task automatic step(output logic st);
    logic [31:0] a, b, r, wd, bt;
    logic [4:0] wr;
    logic ld, es;
    #1;
    es = flush ? 1'b0 : m_busy ? (m_left > 1) : (alu_op_in == OP_MUL);
    check("stall", 32'(stall), 32'(es));
    st = stall;
    a  = fwd(rs_in, read_data1_in);
    wd = fwd(rt_in, read_data2_in);
    b  = alu_src_in ? sign_ext_in : wd;
    bt = pc_in + sign_ext_in * 4;
    wr = reg_dst_in ? rd_in : rt_in;
    r  = alu(alu_op_in, a, b);
    ld = 1'b0;
    if (flush) m_busy = 1'b0;
    else if (m_busy) begin
      if (m_left == 1) begin
        ld = 1'b1;
        r = m_prod;
        m_busy = 1'b0;
      end else m_left--;
    end else if (alu_op_in == OP_MUL) begin
      m_busy = 1'b1;
      m_left = 32;
      m_prod = a * b;
    end else ld = 1'b1;
    @(posedge clk);
    #1;
    {m_rw, m_mtr, m_br, m_mr, m_mw} = ld ? {reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in} : 5'd0;
    m_bub = !ld;
    m_res = r; m_zero = (r == 0); m_wd = wd; m_bt = bt; m_wr = wr;
    check("ctl", 32'({reg_write_out, mem_to_reg_out, branch_out, mem_read_out, mem_write_out}),
          32'({m_rw, m_mtr, m_br, m_mr, m_mw}));
    if (!m_bub) begin
      check("alu_result", alu_result_out, m_res);
      check("zero", 32'(zero_out), 32'(m_zero));
      check("write_data", write_data_out, m_wd);
      check("branch_target", branch_target_out, m_bt);
      check("write_reg", 32'(write_reg_out), 32'(m_wr));
    end
  endtask

  task automatic rand_idex();
    {reg_write_in, mem_to_reg_in, branch_in, mem_read_in, mem_write_in, reg_dst_in, alu_src_in} = 7'($urandom);
    alu_op_in     = 3'($urandom_range(0, 7));
    pc_in         = $urandom;
    read_data1_in = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 9);
    read_data2_in = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 9);
    sign_ext_in   = $urandom_range(0, 1) ? $urandom : 32'($signed(8'($urandom)));
    rs_in = 5'($urandom_range(0, 3));
    rt_in = 5'($urandom_range(0, 3));
    rd_in = 5'($urandom_range(0, 3));
  endtask

  task automatic rand_memwb();
    memwb_reg_write = 1'($urandom);
    memwb_rd        = 5'($urandom_range(0, 3));
    memwb_data      = $urandom;
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    {mem_to_reg_in, branch_in, mem_read_in, mem_write_in, alu_src_in} = '0;
    reg_write_in = 1'b1; reg_dst_in = 1'b1; flush = 1'b0;
    alu_op_in = op; read_data1_in = a; read_data2_in = b;
    rs_in = rs; rt_in = rt; rd_in = rd; pc_in = '0; sign_ext_in = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_zero(tag);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_zero({tag, "_hold"});
    reset = 1'b1;
  endtask

  initial begin : main
    logic st, held, done;
    int n, stalls, bubbles;
    reset = 1'b1;
    rand_idex();
    rand_memwb();
    alu_op_in = OP_MUL;
    flush = 1'b0;
    model_clear();
    #3;
    do_reset("reset");

    set_alu(OP_ADD, 5, 7, 1, 2, 3);
    step(st);
    check("add_5_7", alu_result_out, 32'd12);
    check("add_5_7_zero", 32'(zero_out), 32'd0);

    set_alu(OP_ADD, 3, 4, 4, 5, 1);
    step(st);
    set_alu(OP_SUB, 55, 66, 1, 1, 2);
    memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_data = 32'd99;
    step(st);
    check("fwd_prio_res", alu_result_out, 32'd0);
    check("fwd_prio_zero", 32'(zero_out), 32'd1);

    set_alu(OP_ADD, 3, 4, 6, 7, 0);
    step(st);
    check("r0_write_reg", 32'(write_reg_out), 32'd0);
    check("r0_write_rw", 32'(reg_write_out), 32'd1);
    set_alu(OP_ADD, 10, 20, 0, 0, 8);
    memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_data = 32'd99;
    step(st);
    check("r0_no_fwd", alu_result_out, 32'd30);

    set_alu(OP_SUB, 5, 5, 9, 10, 11);
    pc_in = 32'h100; sign_ext_in = 32'hFFFF_FFFE;
    step(st);
    check("branch_target", branch_target_out, 32'h0000_00F8);
    check("branch_zero", 32'(zero_out), 32'd1);

    set_alu(OP_SLT, 32'hFFFF_FFFF, 1, 12, 13, 14);
    step(st);
    check("slt_m1_1", alu_result_out, 32'd1);
    set_alu(OP_SLT, 1, 32'hFFFF_FFFF, 15, 16, 17);
    step(st);
    check("slt_1_m1", alu_result_out, 32'd0);
    set_alu(OP_NOR, 0, 0, 18, 19, 20);
    step(st);
    check("nor_0_0", alu_result_out, 32'hFFFF_FFFF);
    set_alu(OP_XOR, 32'hF0F0, 32'hFF00, 21, 22, 23);
    step(st);
    check("xor", alu_result_out, 32'h0FF0);

    set_alu(OP_MUL, 32'hFFFF_FFFF, 3, 24, 25, 26);
    n = 0; stalls = 0; bubbles = 0; done = 1'b0;
    while (!done && n < 40) begin
      step(st);
      n++;
      if (st) stalls++;
      if (reg_write_out) done = 1'b1;
      else bubbles++;
    end
    check("mul_latency", n, 33);
    check("mul_stalls", stalls, 32);
    check("mul_bubbles", bubbles, 32);
    check("mul_result", alu_result_out, 32'hFFFF_FFFD);
    check("mul_rw", 32'(reg_write_out), 32'd1);

    set_alu(OP_MUL, 7, 9, 27, 28, 29);
    step(st);
    repeat (10) step(st);
    flush = 1'b1;
    step(st);
    check("flush_stall", 32'(st), 32'd0);
    check("flush_bubble", 32'(reg_write_out), 32'd0);
    set_alu(OP_ADD, 2, 2, 30, 31, 5);
    step(st);
    check("after_flush_add", alu_result_out, 32'd4);
    check("after_flush_stall", 32'(st), 32'd0);

    set_alu(OP_MUL, 7, 9, 27, 28, 29);
    pc_in = 32'h40;
    repeat (6) step(st);
    #2;
    do_reset("mul_reset");
    set_alu(OP_ADD, 8, 9, 1, 2, 3);
    step(st);
    check("after_reset_add", alu_result_out, 32'd17);
    check("after_reset_stall", 32'(st), 32'd0);

    held = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rand_idex();
        rand_memwb();
        #2;
        do_reset("rand_reset");
        held = 1'b0;
      end
      if (!held) rand_idex();
      rand_memwb();
      flush = ($urandom_range(0, 24) == 0);
      step(st);
      held = st;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
